// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into
// 32-bit words and writes them at word indices 0..N-1 while holding the CPU.
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_EXT   = (ADDR_W+1)'(1);

    state_t              state;
    state_t              state_next;
    logic [1:0]          byte_idx;
    logic [ADDR_W-1:0]   word_idx;
    logic [ADDR_W:0]     count;
    logic [31:0]         asm_word;
    logic [ADDR_W-1:0]   waddr_q;
    logic [31:0]         wdata_q;
    logic                done_q;
    logic                error_q;
    logic                accept;
    logic                last_word;
    logic                start_ok;

    assign accept    = (state == RECV) && byte_valid;
    assign last_word = ({1'b0, word_idx} + ONE_EXT) == count;
    assign start_ok  = start && (word_count != '0)
                       && (word_count <= MAX_WORDS);

    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign error     = error_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state: a word is four accepted bytes, then one write cycle
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start_ok) state_next = RECV;
            RECV:    if (accept && byte_idx == 2'd3) state_next = WRITE;
            WRITE:   state_next = last_word ? IDLE : RECV;
            default: state_next = IDLE;
        endcase
    end

    // Decoded outputs; the CPU is held for exactly as long as a load runs
    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        cpu_hold   = 1'b0;
        unique case (state)
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                cpu_hold   = 1'b1;
            end
            WRITE: begin
                mem_we   = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: byte assembly, write-port registers and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx <= '0;
            word_idx <= '0;
            count    <= '0;
            asm_word <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        count    <= word_count;
                        word_idx <= '0;
                        byte_idx <= '0;
                        if (word_count == '0) begin
                            done_q  <= 1'b1;
                            error_q <= 1'b0;
                        end else if (word_count > MAX_WORDS) begin
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                        end else begin
                            done_q  <= 1'b0;
                            error_q <= 1'b0;
                        end
                    end
                end
                RECV: begin
                    if (accept) begin
                        asm_word[8*byte_idx +: 8] <= byte_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            waddr_q <= word_idx;
                            wdata_q <= {byte_data, asm_word[23:0]};
                        end
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + ADDR_W'(1);
                    if (last_word) done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
